// File: rtl/rvlab_drp_responder.sv
// rvlab_drp_responder
// Slave end of the 7-series MMCM Dynamic Reconfiguration Port. It emulates the
// MMCM's DRP register file, the DRDY response timing and the LOCKED sequence.
// It also reports the CLKOUT0 divide that the emulated MMCM would currently
// produce.
//
// Optional feature: define RVLAB_DRP_RSP_ADDR_CHECK_EN to implement only
// addresses 0x00-0x4F. Accesses above that range still complete with DRDY.
// Such reads return 0 and such writes are dropped. Both set proto_err_o.
//
// Ports:
//   clk_i          DRP clock (DCLK)
//   rst_ni         asynchronous active-low reset
//   drp_en_i       DEN, one-cycle request strobe
//   drp_we_i       DWE, marks the request as a write
//   drp_adr_i      DADDR (7 bits)
//   drp_di_i       DI, write data (16 bits)
//   drp_rdy_o      DRDY, one-cycle completion pulse
//   drp_do_o       DO, read data, valid while drp_rdy_o=1, otherwise 0
//   mmcm_rst_i     emulated MMCM RST
//   locked_o       emulated LOCKED
//   clkout0_div_o  effective CLKOUT0 divide (1..128)
//   proto_err_o    sticky protocol-violation flag
module rvlab_drp_responder #(
    parameter int RDY_LATENCY = 4,
    parameter int LOCK_DELAY  = 64,
    parameter int DIV_DEFAULT = 18
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        drp_en_i,
    input  logic        drp_we_i,
    input  logic [6:0]  drp_adr_i,
    input  logic [15:0] drp_di_i,
    output logic        drp_rdy_o,
    output logic [15:0] drp_do_o,
    input  logic        mmcm_rst_i,
    output logic        locked_o,
    output logic [7:0]  clkout0_div_o,
    output logic        proto_err_o
);

    localparam int DIV_HIGH = DIV_DEFAULT / 2;
    localparam int DIV_LOW  = DIV_DEFAULT - DIV_HIGH;
    localparam logic [15:0] CLKREG1_RST = {4'b0001, 6'(DIV_HIGH), 6'(DIV_LOW)};

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [6:0]  adr_q;
    logic        we_q;
    logic        ok_q;
    logic [15:0] di_q;
    logic [15:0] rd_q;
    logic [15:0] regs [128];
    logic [9:0]  lock_cnt;
    logic        adr_ok;
    logic [15:0] rd_now;

`ifdef RVLAB_DRP_RSP_ADDR_CHECK_EN
    assign adr_ok = (drp_adr_i <= 7'h4F);
`else
    assign adr_ok = 1'b1;
`endif

    assign rd_now = adr_ok ? regs[drp_adr_i] : 16'h0000;

    // The MMCM treats a zero counter field as 64. NO_COUNT bypasses the divider.
    function automatic logic [7:0] calc_div(input logic [15:0] clkreg1, input logic no_count);
        logic [7:0] high;
        logic [7:0] low;
        high = (clkreg1[11:6] == 6'd0) ? 8'd64 : {2'b00, clkreg1[11:6]};
        low  = (clkreg1[5:0]  == 6'd0) ? 8'd64 : {2'b00, clkreg1[5:0]};
        return no_count ? 8'd1 : 8'(high + low);
    endfunction

    // DRP transaction FSM and register file
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            ok_q        <= 1'b0;
            di_q        <= '0;
            rd_q        <= '0;
            drp_rdy_o   <= 1'b0;
            drp_do_o    <= '0;
            proto_err_o <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                regs[i] <= (i == 8) ? CLKREG1_RST : 16'h0000;
            end
        end else begin
            drp_rdy_o <= 1'b0;
            drp_do_o  <= '0;
            case (state)
                IDLE: begin
                    if (drp_en_i) begin
                        adr_q <= drp_adr_i;
                        we_q  <= drp_we_i;
                        ok_q  <= adr_ok;
                        di_q  <= drp_di_i;
                        rd_q  <= rd_now;
                        cnt   <= 4'(RDY_LATENCY - 1);
                        // Reconfiguring a running MMCM is a protocol error, but the write still lands.
                        if ((drp_we_i && !mmcm_rst_i) || !adr_ok) begin
                            proto_err_o <= 1'b1;
                        end
                        if (RDY_LATENCY == 1) begin
                            state     <= RESP;
                            drp_rdy_o <= 1'b1;
                            drp_do_o  <= drp_we_i ? 16'h0000 : rd_now;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (drp_en_i) begin
                        proto_err_o <= 1'b1;
                    end
                    // drp_rdy_o is registered, so leave BUSY one count early.
                    if (cnt <= 4'd1) begin
                        state     <= RESP;
                        drp_rdy_o <= 1'b1;
                        drp_do_o  <= we_q ? 16'h0000 : rd_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (drp_en_i) begin
                        proto_err_o <= 1'b1;
                    end
                    if (we_q && ok_q) begin
                        regs[adr_q] <= di_q;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lock sequencer and divide capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_cnt      <= '0;
            locked_o      <= 1'b0;
            clkout0_div_o <= 8'(DIV_DEFAULT);
        end else if (mmcm_rst_i) begin
            lock_cnt <= '0;
            locked_o <= 1'b0;
        end else if (lock_cnt != 10'(LOCK_DELAY)) begin
            lock_cnt <= lock_cnt + 10'd1;
            if (lock_cnt == 10'(LOCK_DELAY - 1)) begin
                locked_o <= 1'b1;
                // A write that commits on this same edge is not seen here.
                clkout0_div_o <= calc_div(regs[8], regs[9][6]);
            end
        end
    end

endmodule

// File: tb/tb_rvlab_drp_responder.sv
module tb_rvlab_drp_responder;

    localparam int LAT  = 4;
    localparam int LOCK = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        drp_en;
    logic        drp_we;
    logic [6:0]  drp_adr;
    logic [15:0] drp_di;
    logic        drp_rdy;
    logic [15:0] drp_do;
    logic        mmcm_rst;
    logic        locked;
    logic [7:0]  div;
    logic        perr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    rvlab_drp_responder #(.RDY_LATENCY(LAT), .LOCK_DELAY(LOCK), .DIV_DEFAULT(18)) dut (
        .clk_i(clk), .rst_ni(rst_n), .drp_en_i(drp_en), .drp_we_i(drp_we),
        .drp_adr_i(drp_adr), .drp_di_i(drp_di), .drp_rdy_o(drp_rdy), .drp_do_o(drp_do),
        .mmcm_rst_i(mmcm_rst), .locked_o(locked), .clkout0_div_o(div), .proto_err_o(perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every DRDY must match the head of the scoreboard in cycle and data.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drp_rdy) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL drdy_unexpected: DRDY at cycle %0d do=%h, required no DRDY", cyc, drp_do);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cyc != e.due || drp_do != e.data) begin
                        bad++;
                        $display("FAIL drdy_resp: got cycle %0d do=%h, required cycle %0d do=%h",
                                 cyc, drp_do, e.due, e.data);
                    end
                end
            end else if (drp_do != 16'h0000) begin
                total++;
                bad++;
                $display("FAIL do_idle: do=%h without DRDY, required 0000", drp_do);
            end
        end
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Issue one DRP op at #1 after an edge and return at #1 after the edge following IDLE re-entry.
    task automatic drp_op(input logic we, input logic [6:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
        exp_t e;
        e.due  = cyc + LAT;
        e.data = we ? 16'h0000 : exp_rd;
        sb.push_back(e);
        drp_en = 1'b1; drp_we = we; drp_adr = a; drp_di = d;
        @(posedge clk); #1;
        drp_en = 1'b0; drp_we = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input string nm);
        repeat (LOCK - 1) @(posedge clk);
        #1 check({nm, "_locked_early"}, 16'(locked), 16'h0);
        @(posedge clk);
        #1 check({nm, "_locked"}, 16'(locked), 16'h1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drp_en = 0; drp_we = 0; drp_adr = 0; drp_di = 0; mmcm_rst = 1'b1;
        @(posedge clk); #1;
        do_reset();

        check("rst_rdy", 16'(drp_rdy), 16'h0);
        check("rst_do", drp_do, 16'h0000);
        check("rst_locked", 16'(locked), 16'h0);
        check("rst_div", 16'(div), 16'd18);
        check("rst_perr", 16'(perr), 16'h0);

        // Default ClkReg1 and first-transaction latency
        drp_op(1'b0, 7'h08, 16'h0, 16'h1249);

        // Divide 6+6 programmed under reset
        drp_op(1'b1, 7'h08, 16'h1186, 16'h0);
        drp_op(1'b0, 7'h08, 16'h0, 16'h1186);
        mmcm_rst = 1'b0;
        wait_lock("lock12");
        check("div12", 16'(div), 16'd12);
        check("perr_clean", 16'(perr), 16'h0);

        // NO_COUNT forces divide 1
        mmcm_rst = 1'b1;
        drp_op(1'b1, 7'h09, 16'h0040, 16'h0);
        check("div_hold", 16'(div), 16'd12);
        mmcm_rst = 1'b0;
        wait_lock("lock1");
        check("div1", 16'(div), 16'd1);

        // Zero high/low fields count as 64 each
        mmcm_rst = 1'b1;
        drp_op(1'b1, 7'h08, 16'h1000, 16'h0);
        drp_op(1'b1, 7'h09, 16'h0000, 16'h0);
        mmcm_rst = 1'b0;
        wait_lock("lock128");
        check("div128", 16'(div), 16'd128);
        check("perr_clean2", 16'(perr), 16'h0);

        // Out-of-range address behaviour (writes under reset)
        mmcm_rst = 1'b1;
`ifdef RVLAB_DRP_RSP_ADDR_CHECK_EN
        drp_op(1'b1, 7'h7F, 16'hBEEF, 16'h0);
        drp_op(1'b0, 7'h7F, 16'h0, 16'h0000);
        check("range_perr", 16'(perr), 16'h1);
`else
        drp_op(1'b1, 7'h7F, 16'hBEEF, 16'h0);
        drp_op(1'b0, 7'h7F, 16'h0, 16'hBEEF);
        check("range_perr", 16'(perr), 16'h0);
`endif

        // Write while the MMCM is running
        mmcm_rst = 1'b0;
        wait_lock("lock_run");
        drp_op(1'b1, 7'h10, 16'h5A5A, 16'h0);
        check("run_write_perr", 16'(perr), 16'h1);
        drp_op(1'b0, 7'h10, 16'h0, 16'h5A5A);

        // Reset reassertion at lock count 30 restarts the sequence
        mmcm_rst = 1'b1;
        @(posedge clk); #1;
        mmcm_rst = 1'b0;
        repeat (30) @(posedge clk);
        #1 mmcm_rst = 1'b1;
        @(posedge clk); #1;
        check("restart_locked", 16'(locked), 16'h0);
        mmcm_rst = 1'b0;
        wait_lock("lock_restart");
        check("div_restart", 16'(div), 16'd128);

        // Full reset clears registers and the error flag
        mmcm_rst = 1'b1;
        do_reset();
        check("rst2_perr", 16'(perr), 16'h0);
        check("rst2_div", 16'(div), 16'd18);
        drp_op(1'b0, 7'h10, 16'h0, 16'h0000);

        // Second DEN two cycles into a transaction is ignored
        begin
            exp_t e;
            e.due = cyc + LAT;
            e.data = 16'h1249;
            sb.push_back(e);
        end
        drp_en = 1'b1; drp_adr = 7'h08;
        @(posedge clk); #1 drp_en = 1'b0;
        @(posedge clk); #1 drp_en = 1'b1; drp_adr = 7'h10;
        @(posedge clk); #1 drp_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("overlap_perr", 16'(perr), 16'h1);

        // Reset during a transaction: no DRDY may follow
        drp_en = 1'b1; drp_adr = 7'h08;
        @(posedge clk); #1 drp_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        drp_op(1'b0, 7'h08, 16'h0, 16'h1249);

        check("sb_drained", 16'(sb.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rvlab_drp_responder.md
Name: rvlab_drp_responder

Overview:
Synthesizable responder for the Xilinx 7-series MMCM Dynamic Reconfiguration Port (DRP). It is the slave end of the DRP protocol, emulating the MMCM's DRP register file, DRDY timing, and LOCKED behaviour. It stands in for the MMCM in simulation and FPGA self-test of the TL-UL-to-DRP adapter and the clock reconfiguration safety net. It also reports the CLKOUT0 divide value the emulated MMCM would currently produce.

Parameters:
RDY_LATENCY, 4, cycles from DEN acceptance to the DRDY pulse (1..15)
LOCK_DELAY, 64, cycles after mmcm_rst_i release until locked_o rises (1..1023)
DIV_DEFAULT, 18, reset CLKOUT0 divide; reset content of ClkReg1 (addr 0x08) is high = DIV_DEFAULT/2, low = DIV_DEFAULT - high

Ports:
clk_i  in  1  DRP clock (DCLK)
rst_ni  in  1  asynchronous active-low reset
drp_en_i  in  1  DEN; one-cycle request strobe
drp_we_i  in  1  DWE; qualifies drp_en_i as a write
drp_adr_i  in  7  DADDR
drp_di_i  in  16  DI; write data
drp_rdy_o  out  1  DRDY; one-cycle completion pulse
drp_do_o  out  16  DO; read data, valid while drp_rdy_o=1
mmcm_rst_i  in  1  emulated MMCM RST
locked_o  out  1  emulated LOCKED
clkout0_div_o  out  8  effective CLKOUT0 divide (1..128)
proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: drp_rdy_o=0, drp_do_o=0, locked_o=0, clkout0_div_o=DIV_DEFAULT, proto_err_o=0, FSM=IDLE.
- Register file: 128 x 16 bits. Every entry resets to 0, except addr 0x08 = {4'b0001, 6'(high), 6'(low)} (phase mux 0, bit 12 reserved set).
- FSM IDLE:
  - drp_en_i=1 latches adr, we and di; read data is captured from the register file in the same cycle.
  - Load counter with RDY_LATENCY-1; go to BUSY (RDY_LATENCY=1 goes directly to RESP).
- FSM BUSY: decrement the counter; at 0 go to RESP.
- FSM RESP (one cycle):
  - drp_rdy_o=1.
  - Read: drp_do_o = captured data.
  - Write: the register is written this cycle; drp_do_o=0.
  - Next state IDLE.
- Timing: a request accepted in cycle N gives drp_rdy_o=1 in cycle N+RDY_LATENCY. A new DEN is accepted no earlier than cycle N+RDY_LATENCY+1.
- drp_do_o returns to 0 in the cycle after RESP.
- DEN while BUSY or RESP: ignored; proto_err_o<=1.
- DEN with we=1 while mmcm_rst_i=0: the write is performed; proto_err_o<=1 (the real MMCM must be held in reset during reconfiguration).
- proto_err_o is cleared only by rst_ni.
- Lock model:
  - While mmcm_rst_i=1: locked_o=0 and the lock counter is 0.
  - After release: count up each cycle; locked_o=1 when the count reaches LOCK_DELAY; then saturate.
  - Reassertion of mmcm_rst_i mid-count restarts the sequence.
- Divide update:
  - On the cycle locked_o rises, clkout0_div_o <= high+low from addr 0x08 bits [11:6] and [5:0]; a zero field counts as 64.
  - If addr 0x09 bit 6 (NO_COUNT) is set, clkout0_div_o <= 1.
  - clkout0_div_o holds between lock events. 8-bit unsigned add; maximum 128.
- Simultaneous events:
  - mmcm_rst_i does not abort a DRP transaction; DRDY still occurs at the stated latency.
  - A write completing in the same cycle that locked_o rises is not reflected until the next lock.
- rst_ni assertion mid-transaction: FSM returns to IDLE immediately; no DRDY is issued.

Optional Feature:
Macro RVLAB_DRP_RSP_ADDR_CHECK_EN.
- Defined: only addresses 0x00-0x4F are implemented.
  - Accesses above 0x4F still complete with DRDY at normal latency.
  - Reads return 0; writes are discarded; proto_err_o<=1.
- Undefined: all 128 addresses are read/write with no range check.

Test Plan:
- Reset release -> drp_rdy_o=0, locked_o=0, clkout0_div_o=18; read addr 0x08 returns 0x1249 with drp_rdy_o high exactly 4 cycles after DEN.
- mmcm_rst_i=1, write 0x08=0x1186 (high 6, low 6), release reset -> locked_o=1 exactly 64 cycles after release; clkout0_div_o=12; proto_err_o=0.
- Write 0x09 bit 6 set under reset, release -> clkout0_div_o=1; write 0x08 low=0 and high=0, clear NO_COUNT, relock -> clkout0_div_o=128.
- DEN issued 2 cycles after a previous DEN -> second request ignored, proto_err_o=1; only one DRDY observed.
- Write with mmcm_rst_i=0 -> data stored, proto_err_o=1; reassert mmcm_rst_i at lock count 30 -> locked_o stays 0 and the 64-cycle count restarts.
- With RVLAB_DRP_RSP_ADDR_CHECK_EN: write 0x7F=0xBEEF, read 0x7F -> DRDY at latency 4, drp_do_o=0, proto_err_o=1; without the macro, the read returns 0xBEEF and proto_err_o stays 0 (writes under reset).
